instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory with a runtime program loader.
- Replaces the fixed, preloaded instruction RAM.
- A host streams a program in through a valid/ready load port, then the processor fetches through a registered fetch port.
- Out-of-range fetches are trapped and return NOP, so the core never executes stale or undefined words.

Parameters:
- DATA_W, 16: instruction word width.
- ADDR_W, 8: fetch address width.
- DEPTH, 256: number of words; must be ≤ 2^ADDR_W and ≥ 2.
- NOP_OPCODE, 50: word returned on a trapped fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  enter LOAD; restarts the write pointer at 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  program word.
- load_last  in  1  qualifies the final word of the load.
- load_ready  out  1  high only in LOAD.
- run_start  in  1  IDLE→RUN using existing contents.
- fetch_en  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch address.
- instr_out  out  DATA_W  fetched word.
- instr_valid  out  1  instr_out is valid this cycle.
- fetch_err  out  1  1-cycle pulse aligned with instr_valid; the fetch was out of range.
- prog_len  out  ADDR_W+1  number of loaded words.
- mode  out  2  state: 0 IDLE, 1 LOAD, 2 RUN.

Behaviour:
- Reset values:
  - mode=IDLE, prog_len=0, wr_ptr=0.
  - instr_out=0, instr_valid=0, fetch_err=0.
  - load_ready=0.
  - Memory array is not cleared.
- IDLE state:
  - load_start → LOAD (wr_ptr=0).
  - Else run_start → RUN with prog_len=DEPTH.
  - load_start has priority over run_start.
  - fetch_en is ignored.
- LOAD state:
  - load_ready=1.
  - A word is accepted when load_valid=1: mem[wr_ptr]<=load_data, wr_ptr++.
  - Termination: an accepted word with load_last=1, or wr_ptr==DEPTH-1, writes the word, sets prog_len=wr_ptr+1 and moves to RUN the next cycle.
  - load_valid=0 inserts a bubble; nothing is written.
  - load_start in LOAD restarts at wr_ptr=0 and drops that cycle's word.
  - Overflow is impossible: the transition happens on the DEPTH-th word.
- RUN state:
  - fetch_en=1 registers a read with 1-cycle latency.
  - Next cycle: instr_valid=1 and instr_out=mem[fetch_addr].
  - If fetch_addr ≥ prog_len: instr_out=NOP_OPCODE and fetch_err=1.
  - Back-to-back fetches give one result per cycle.
  - fetch_en=0: next cycle instr_valid=0 and instr_out holds its last value.
- RUN exits:
  - load_start → LOAD.
  - A fetch in the same cycle is dropped: instr_valid=0 the next cycle.
  - prog_len holds its old value until the new load terminates.
  - run_start in RUN is ignored.
- Widths:
  - prog_len is ADDR_W+1 bits so it can hold DEPTH.
  - Range compare is unsigned, zero-extended.
- Reset mid-LOAD: partial words stay in memory, but prog_len=0 and mode=IDLE. A subsequent run_start exposes all DEPTH words (documented hazard: the host must reload).
- Simultaneous events in LOAD: load_valid with load_start — restart wins and no write occurs.
- No internal write/read collision: writes occur only in LOAD and reads only in RUN.

Test Plan:
- Normal load: reset, load_start, stream 0x0026, 0x0101, 0x0009 (last) → prog_len=3, mode=RUN. Fetch addr 1 → next cycle instr_out=0x0101, instr_valid=1, fetch_err=0.
- Out-of-range fetch: after the 3-word load, fetch addr 3 and addr 255 → instr_out=50, fetch_err=1 each, aligned with instr_valid.
- Full load: DEPTH=8, stream 8 words 0..7 without load_last → RUN after the 8th word, prog_len=8. Fetches 0..7 back-to-back → data 0..7 on consecutive cycles.
- Bubbles and restart: load with load_valid gaps → word count correct. Mid-load load_start → the next word lands at addr 0.
- Reload from RUN: load_start with fetch_en=1 in the same cycle → no instr_valid next cycle; prog_len keeps its old value until the new load_last.
- Reset mid-load: after 2 words, reset → mode=0, prog_len=0, outputs zero. run_start → fetch addr 1 returns the previously written word, fetch_err=0.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Purpose : instruction memory with a runtime program loader (IDLE / LOAD / RUN).
// Latency : fetch result one cycle after fetch_en; load writes land on the accepting edge.
// Backpressure: load_ready is high only in LOAD; fetches are never stalled.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   load_start                  enter LOAD with the write pointer at 0 (wins over all else)
//   load_valid/load_data/load_last/load_ready   program stream from the host
//   run_start                   IDLE -> RUN over the existing contents (prog_len = DEPTH)
//   fetch_en/fetch_addr         fetch request, honoured only in RUN
//   instr_out/instr_valid/fetch_err   registered fetch result; trapped fetches return NOP
//   prog_len                    number of loaded words (ADDR_W+1 bits so it can hold DEPTH)
//   mode                        0 IDLE, 1 LOAD, 2 RUN
module instr_mem_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int NOP_OPCODE = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              run_start,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              fetch_err,
    output logic [ADDR_W:0]   prog_len,
    output logic [1:0]        mode
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Index width covers DEPTH-1 only; the range check guarantees any
    // address that reaches the array is below prog_len <= DEPTH.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_OPCODE);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic [IDX_W-1:0]  wr_ptr;
    logic              wr_en;
    logic              load_end;
    logic              out_of_range;

    assign load_ready   = (state == S_LOAD);
    assign mode         = state;
    // A restart in the same cycle drops the offered word.
    assign wr_en        = (state == S_LOAD) && load_valid && !load_start;
    assign load_end     = wr_en && (load_last || (wr_ptr == LAST_PTR));
    assign out_of_range = ({1'b0, fetch_addr} >= prog_len);

    // Array is deliberately not reset: contents survive reset so that
    // run_start can execute whatever was last written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            prog_len    <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state  <= S_LOAD;
                        wr_ptr <= '0;
                    end else if (run_start) begin
                        state    <= S_RUN;
                        prog_len <= FULL_LEN;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        wr_ptr <= '0;
                    end else if (load_end) begin
                        state    <= S_RUN;
                        prog_len <= (ADDR_W+1)'(wr_ptr) + (ADDR_W+1)'(1);
                        wr_ptr   <= '0;
                    end else if (wr_en) begin
                        wr_ptr <= wr_ptr + IDX_W'(1);
                    end
                end
                S_RUN: begin
                    if (load_start) begin
                        // Any fetch this cycle is dropped; prog_len keeps
                        // its old value until the new load terminates.
                        state  <= S_LOAD;
                        wr_ptr <= '0;
                    end else if (fetch_en) begin
                        instr_valid <= 1'b1;
                        if (out_of_range) begin
                            instr_out <= NOP_WORD;
                            fetch_err <= 1'b1;
                        end else begin
                            instr_out <= mem[fetch_addr[IDX_W-1:0]];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Purpose : directed bench for instr_mem_ctrl with a fetch-result scoreboard.
// Latency : expects each fetch result one cycle after the request.
// Backpressure: none exercised on fetch; load stream uses bubbles and restarts.
module tb_instr_mem_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 8;
    localparam int NOP    = 50;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              run_start;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              fetch_err;
    logic [ADDR_W:0]   prog_len;
    logic [1:0]        mode;

    int vectors     = 0;
    int miscompares = 0;

    // Expected fetch results: {fetch_err, instr_out}
    logic [DATA_W:0] exp_q [$];

    always #5 clk = ~clk;

    instr_mem_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_OPCODE(NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .run_start(run_start),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .instr_out(instr_out),
        .instr_valid(instr_valid), .fetch_err(fetch_err), .prog_len(prog_len),
        .mode(mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented result.
    initial begin
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL fetch_unexpected: got instr=0x%0h err=%0b, none expected",
                             instr_out, fetch_err);
                end else begin
                    logic [DATA_W:0] e;
                    e = exp_q.pop_front();
                    if ({fetch_err, instr_out} !== e) begin
                        miscompares++;
                        $display("FAIL fetch_result: got err=%0b instr=0x%0h expected err=%0b instr=0x%0h",
                                 fetch_err, instr_out, e[DATA_W], e[DATA_W-1:0]);
                    end
                end
            end else if (fetch_err) begin
                vectors++;
                miscompares++;
                $display("FAIL err_alignment: got fetch_err=1 with instr_valid=0, expected 0");
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        run_start  = 1'b0; fetch_en   = 1'b0; fetch_addr = '0;
    endtask

    task automatic start_load();
        idle_inputs();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        cyc();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic bubble();
        load_valid = 1'b0;
        cyc();
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic err);
        fetch_en = 1'b1; fetch_addr = a;
        exp_q.push_back({err, d});
        cyc();
    endtask

    task automatic end_fetch();
        fetch_en = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_mode", 32'(mode), 0);
        check("rst_prog_len", 32'(prog_len), 0);
        check("rst_instr_out", 32'(instr_out), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        check("rst_load_ready", 32'(load_ready), 0);

        // Normal 3-word load
        start_load();
        check("load_mode", 32'(mode), 1);
        check("load_ready_hi", 32'(load_ready), 1);
        send_word(16'h0026, 1'b0);
        send_word(16'h0101, 1'b0);
        send_word(16'h0009, 1'b1);
        check("load3_mode", 32'(mode), 2);
        check("load3_prog_len", 32'(prog_len), 3);
        check("run_load_ready_lo", 32'(load_ready), 0);

        // In-range and trapped fetches, back to back
        fetch(8'd1,   16'h0101, 1'b0);
        fetch(8'd3,   16'(NOP), 1'b1);
        fetch(8'd255, 16'(NOP), 1'b1);
        fetch(8'd0,   16'h0026, 1'b0);
        end_fetch();
        check("hold_valid_lo", 32'(instr_valid), 0);
        check("hold_instr_out", 32'(instr_out), 32'h0026);

        // Reload from RUN with a simultaneous fetch (dropped)
        load_start = 1'b1; fetch_en = 1'b1; fetch_addr = 8'd0;
        cyc();
        idle_inputs();
        check("drop_valid_lo", 32'(instr_valid), 0);
        check("reload_mode", 32'(mode), 1);
        check("reload_prog_len_hold", 32'(prog_len), 3);

        // Bubbles and a mid-load restart that drops its word
        send_word(16'hAAAA, 1'b0);
        bubble();
        check("bubble_prog_len_hold", 32'(prog_len), 3);
        load_start = 1'b1;
        send_word(16'hBBBB, 1'b0);
        load_start = 1'b0;
        send_word(16'h1111, 1'b0);
        bubble();
        send_word(16'h2222, 1'b1);
        check("restart_mode", 32'(mode), 2);
        check("restart_prog_len", 32'(prog_len), 2);
        fetch(8'd0, 16'h1111, 1'b0);
        fetch(8'd1, 16'h2222, 1'b0);
        fetch(8'd2, 16'(NOP), 1'b1);
        end_fetch();

        // Full load: DEPTH words without load_last
        start_load();
        for (int i = 0; i < DEPTH - 1; i++) begin
            send_word(16'(i), 1'b0);
            if (i == 3) bubble();
        end
        check("full_pre_mode", 32'(mode), 1);
        send_word(16'(DEPTH - 1), 1'b0);
        check("full_mode", 32'(mode), 2);
        check("full_prog_len", 32'(prog_len), DEPTH);
        for (int i = 0; i < DEPTH; i++) fetch(8'(i), 16'(i), 1'b0);
        fetch(8'(DEPTH), 16'(NOP), 1'b1);
        end_fetch();

        // Reset in the middle of a load
        start_load();
        send_word(16'h00AB, 1'b0);
        send_word(16'h00CD, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_mode", 32'(mode), 0);
        check("mid_rst_prog_len", 32'(prog_len), 0);
        check("mid_rst_instr_out", 32'(instr_out), 0);
        check("mid_rst_valid", 32'(instr_valid), 0);
        fetch_en = 1'b1; fetch_addr = 8'd1;
        cyc();
        fetch_en = 1'b0;
        check("idle_fetch_ignored", 32'(instr_valid), 0);
        run_start = 1'b1;
        cyc();
        run_start = 1'b0;
        check("run_start_mode", 32'(mode), 2);
        check("run_start_prog_len", 32'(prog_len), DEPTH);
        fetch(8'd1, 16'h00CD, 1'b0);
        fetch(8'd7, 16'h0007, 1'b0);
        end_fetch();

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
